// File: rtl/crc_frame_rx.sv
// crc_frame_rx: bit-serial frame receiver with CRC check.
// Samples qualified serial bits while frame is high, runs the CRC, packs bits
// MSB-first into bytes and holds back the trailing CRC bytes so only payload
// is emitted. At frame end it reports CRC/alignment/length status together
// with a one-cycle done pulse.
`timescale 1ns/1ps

module crc_frame_rx #(
    parameter int               CRC_W    = 32,
    parameter logic [31:0]      CRC_POLY = 32'h04C11DB7,
    parameter logic [CRC_W-1:0] CRC_INIT = '1,
    parameter int               LEN_W    = 16,
    parameter int               MAX_LEN  = 1500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    output logic             done,
    output logic             crc_ok,
    output logic             err_align,
    output logic             err_short,
    output logic             err_long,
    output logic [LEN_W-1:0] frame_len
);

    localparam int               DEPTH  = CRC_W / 8;
    localparam int               FILL_W = $clog2(DEPTH + 1);
    localparam logic [CRC_W-1:0] POLY   = CRC_POLY[CRC_W-1:0];
    localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(DEPTH);

    typedef enum logic [1:0] {HUNT, IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CRC_W-1:0]  sr;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_byte;
    logic [7:0]        line [DEPTH];
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic              start;
    logic              take_bit;
    logic              finish;
    logic              push;
    logic              pop;
    logic [7:0]        new_byte;

    // One serial CRC step: shift left, fold in the polynomial when the
    // outgoing MSB differs from the incoming bit.
    function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] s, input logic b);
        logic fb;
        fb = s[CRC_W-1] ^ b;
        return {s[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    assign new_byte = {shift_byte[6:0], bit_in};
    assign push     = take_bit && (bit_cnt == 3'd7);
    assign pop      = push && (fill == FULL);

    // State register; reset drops into HUNT so a frame already in flight is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the per-cycle datapath strobes and the done pulse.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        start      = 1'b0;
        take_bit   = 1'b0;
        finish     = 1'b0;
        case (state)
            HUNT: begin
                if (!frame) state_next = IDLE;
            end
            IDLE: begin
                if (frame && bit_en) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!frame) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (bit_en) begin
                    take_bit = 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                // A frame already high here started too early; wait for it to end.
                state_next = frame ? HUNT : IDLE;
            end
            default: state_next = HUNT;
        endcase
    end

    // CRC, byte assembly, delay line, payload output and end-of-frame status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= CRC_INIT;
            bit_cnt    <= '0;
            shift_byte <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            crc_ok     <= 1'b0;
            err_align  <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            frame_len  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            byte_valid <= 1'b0;
            if (start) begin
                sr         <= crc_next(CRC_INIT, bit_in);
                bit_cnt    <= 3'd1;
                shift_byte <= {7'b0, bit_in};
                fill       <= '0;
                overflow   <= 1'b0;
                frame_len  <= '0;
                crc_ok     <= 1'b0;
                err_align  <= 1'b0;
                err_short  <= 1'b0;
                err_long   <= 1'b0;
            end else if (take_bit) begin
                sr         <= crc_next(sr, bit_in);
                bit_cnt    <= bit_cnt + 3'd1;
                shift_byte <= new_byte;
                if (push) begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        line[i] <= line[i-1];
                    end
                    line[0] <= new_byte;
                    if (fill != FULL) fill <= fill + FILL_W'(1);
                end
                if (pop) begin
                    if (frame_len != MAX_L) begin
                        byte_data  <= line[DEPTH-1];
                        byte_valid <= 1'b1;
                        frame_len  <= frame_len + LEN_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end else if (finish) begin
                err_align <= (bit_cnt != 3'd0);
                err_short <= (fill != FULL);
                err_long  <= overflow;
                crc_ok    <= (sr == '0) && (bit_cnt == 3'd0) && (fill == FULL) && !overflow;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_rx.sv
// tb_crc_frame_rx: directed table of frames plus hand-written corner sequences
// for crc_frame_rx with default parameters (CRC-32/MPEG-2, MAX_LEN 1500).
`timescale 1ns/1ps

module tb_crc_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic        bit_en;
    logic        bit_in;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        done;
    logic        crc_ok;
    logic        err_align;
    logic        err_short;
    logic        err_long;
    logic [15:0] frame_len;

    typedef struct {
        int kind;
        int nbits;
        int duty;
        bit corrupt;
        bit ok;
        bit al;
        bit sh;
        bit lg;
        int len;
    } vec_t;

    typedef struct {
        logic        ok;
        logic        al;
        logic        sh;
        logic        lg;
        logic [15:0] len;
    } res_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] tx_bytes[$];
    logic       tx_bits[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_bytes[$];
    res_t       res_q[$];
    res_t       exp_res_q[$];
    vec_t       vecs[8];

    crc_frame_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame      (frame),
        .bit_en     (bit_en),
        .bit_in     (bit_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .done       (done),
        .crc_ok     (crc_ok),
        .err_align  (err_align),
        .err_short  (err_short),
        .err_long   (err_long),
        .frame_len  (frame_len)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Collect payload bytes and end-of-frame status away from the active edge.
    always @(negedge clk) begin
        if (byte_valid) rx_q.push_back(byte_data);
        if (done) res_q.push_back('{crc_ok, err_align, err_short, err_long, frame_len});
    end

    // Hard time limit so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC, byte-wise MSB-first, init all ones, no final XOR.
    function automatic logic [31:0] crc_model();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (tx_bytes[i]) begin
            c = c ^ {tx_bytes[i], 24'h0};
            for (int k = 0; k < 8; k++) begin
                c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic append_crc();
        logic [31:0] c;
        c = crc_model();
        tx_bytes.push_back(c[31:24]);
        tx_bytes.push_back(c[23:16]);
        tx_bytes.push_back(c[15:8]);
        tx_bytes.push_back(c[7:0]);
    endtask

    task automatic load_std();
        tx_bytes.delete();
        for (int i = 0; i < 9; i++) tx_bytes.push_back(8'(32'h31 + i));
        tx_bytes.push_back(8'h03);
        tx_bytes.push_back(8'h76);
        tx_bytes.push_back(8'hE6);
        tx_bytes.push_back(8'hE7);
    endtask

    task automatic build_bits(input int nbits);
        tx_bits.delete();
        foreach (tx_bytes[i]) begin
            for (int b = 7; b >= 0; b--) tx_bits.push_back(tx_bytes[i][b]);
        end
        if (nbits >= 0) begin
            while (tx_bits.size() > nbits) void'(tx_bits.pop_back());
        end
    endtask

    task automatic clear_scoreboard();
        rx_q.delete();
        res_q.delete();
        exp_bytes.delete();
        exp_res_q.delete();
    endtask

    // Drive tx_bits as one frame; duty < 100 inserts random bit_en gaps.
    task automatic apply_stimulus(input int duty, input int gap);
        for (int i = 0; i < tx_bits.size(); i++) begin
            while ($urandom_range(99) >= duty) begin
                @(negedge clk);
                frame  = 1'b1;
                bit_en = 1'b0;
                bit_in = 1'($urandom);
            end
            @(negedge clk);
            frame  = 1'b1;
            bit_en = 1'b1;
            bit_in = tx_bits[i];
        end
        @(negedge clk);
        frame  = 1'b0;
        bit_en = 1'b0;
        bit_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_done(input int want);
        for (int c = 0; c < 16 && res_q.size() < want; c++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_output(input string tag);
        int mism;
        mism = 0;
        check($sformatf("%s.done_count", tag), res_q.size(), exp_res_q.size());
        check($sformatf("%s.byte_count", tag), rx_q.size(), exp_bytes.size());
        for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++) begin
            if (rx_q[i] !== exp_bytes[i]) mism++;
        end
        check($sformatf("%s.byte_mismatches", tag), mism, 0);
        for (int i = 0; i < exp_res_q.size() && i < res_q.size(); i++) begin
            check($sformatf("%s[%0d].crc_ok", tag, i), res_q[i].ok, exp_res_q[i].ok);
            check($sformatf("%s[%0d].err_align", tag, i), res_q[i].al, exp_res_q[i].al);
            check($sformatf("%s[%0d].err_short", tag, i), res_q[i].sh, exp_res_q[i].sh);
            check($sformatf("%s[%0d].err_long", tag, i), res_q[i].lg, exp_res_q[i].lg);
            check($sformatf("%s[%0d].frame_len", tag, i), res_q[i].len, exp_res_q[i].len);
        end
    endtask

    task automatic run_good_std(input string tag);
        clear_scoreboard();
        load_std();
        for (int i = 0; i < 9; i++) exp_bytes.push_back(tx_bytes[i]);
        exp_res_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'd9});
        build_bits(-1);
        apply_stimulus(100, 2);
        wait_done(1);
        check_output(tag);
    endtask

    task automatic run_long(input int n, input string tag);
        clear_scoreboard();
        tx_bytes.delete();
        for (int i = 0; i < n; i++) begin
            tx_bytes.push_back(8'($urandom));
            if (i < 1500) exp_bytes.push_back(tx_bytes[i]);
        end
        exp_res_q.push_back('{n <= 1500, 1'b0, 1'b0, n > 1500, 16'd1500});
        append_crc();
        build_bits(-1);
        apply_stimulus(100, 2);
        wait_done(1);
        check_output(tag);
    endtask

    initial begin
        vecs[0] = '{0, -1, 100, 0, 1, 0, 0, 0, 9};
        vecs[1] = '{0, -1, 100, 1, 0, 0, 0, 0, 9};
        vecs[2] = '{0, -1,  30, 0, 1, 0, 0, 0, 9};
        vecs[3] = '{0, 75, 100, 0, 0, 1, 0, 0, 5};
        vecs[4] = '{0, 24, 100, 0, 0, 0, 1, 0, 0};
        vecs[5] = '{1, -1, 100, 0, 1, 0, 0, 0, 0};
        vecs[6] = '{0, 96, 100, 0, 0, 0, 0, 0, 8};
        vecs[7] = '{0, -1,  30, 1, 0, 0, 0, 0, 9};

        // Reset with a frame already in progress on the line.
        rst_n  = 1'b0;
        frame  = 1'b1;
        bit_en = 1'b1;
        bit_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.byte_valid", byte_valid, 0);
        check("reset.done", done, 0);
        check("reset.crc_ok", crc_ok, 0);
        check("reset.err_align", err_align, 0);
        check("reset.err_short", err_short, 0);
        check("reset.err_long", err_long, 0);
        check("reset.frame_len", frame_len, 0);
        check("reset.byte_data", byte_data, 0);
        clear_scoreboard();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bit_in = 1'($urandom);
        end
        @(negedge clk);
        frame  = 1'b0;
        bit_en = 1'b0;
        repeat (6) @(negedge clk);
        check_output("hunt");

        // Table of directed frames.
        for (int v = 0; v < 8; v++) begin
            clear_scoreboard();
            if (vecs[v].kind == 0) begin
                load_std();
            end else begin
                tx_bytes.delete();
                for (int i = 0; i < 4; i++) tx_bytes.push_back(8'hFF);
            end
            if (vecs[v].corrupt) tx_bytes[3] = tx_bytes[3] ^ 8'h01;
            for (int i = 0; i < vecs[v].len; i++) exp_bytes.push_back(tx_bytes[i]);
            exp_res_q.push_back('{vecs[v].ok, vecs[v].al, vecs[v].sh, vecs[v].lg, 16'(vecs[v].len)});
            build_bits(vecs[v].nbits);
            apply_stimulus(vecs[v].duty, 2);
            wait_done(1);
            check_output($sformatf("vec%0d", v));
        end

        // Frame high during the DONE cycle is ignored until it drops.
        clear_scoreboard();
        load_std();
        for (int i = 0; i < 9; i++) exp_bytes.push_back(tx_bytes[i]);
        exp_res_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'd9});
        build_bits(-1);
        apply_stimulus(100, 1);
        apply_stimulus(100, 2);
        wait_done(2);
        repeat (4) @(negedge clk);
        check_output("done_frame_high");

        // Reset mid-frame aborts it; frame stays high past reset release.
        load_std();
        build_bits(-1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            frame  = 1'b1;
            bit_en = 1'b1;
            bit_in = tx_bits[i];
        end
        @(negedge clk);
        bit_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        clear_scoreboard();
        check("midreset.crc_ok", crc_ok, 0);
        check("midreset.frame_len", frame_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 40; i < 72; i++) begin
            @(negedge clk);
            bit_en = 1'b1;
            bit_in = tx_bits[i];
        end
        @(negedge clk);
        frame  = 1'b0;
        bit_en = 1'b0;
        repeat (10) @(negedge clk);
        check_output("midreset");
        run_good_std("after_reset");

        // Payload length boundary: exactly MAX_LEN, then one byte over.
        run_long(1500, "len_max");
        run_long(1501, "len_over");

        // Back-to-back random frames with the minimum gap.
        clear_scoreboard();
        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(0, 24);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) begin
                tx_bytes.push_back(8'($urandom));
                exp_bytes.push_back(tx_bytes[i]);
            end
            exp_res_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'(n)});
            append_crc();
            build_bits(-1);
            apply_stimulus((f % 2 == 1) ? 30 : 100, 2);
        end
        wait_done(5);
        check_output("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
